sm4_cipher_core: RTL and testbench

Iterative SM4 block cipher datapath: encrypts or decrypts one 128-bit block in 32 rounds, one round per clock, using the 32 round keys produced by the key-expansion stage directly upstream. Sits between the key-expansion block and the mode/stream wrapper. Blocks move in and out over valid/ready handshakes.

---
 rtl/sm4_pkg.sv | 20 ++
 rtl/sbox.sv | 29 ++
 rtl/sm4_cipher_core.sv | 108 ++++++++++
 tb/tb_sm4_cipher_core.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared types, constants and the round linear transform for the SM4 datapath.
package sm4_pkg;

  localparam int unsigned SM4_ROUNDS = 32;

  typedef logic [31:0] sm4_word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sm4_core_state_e;

  // Encryption linear transform L(B) = B ^ rol2 ^ rol10 ^ rol18 ^ rol24.
  function automatic sm4_word_t sm4_l(input sm4_word_t b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^
           {b[7:0], b[31:8]};
  endfunction

endpackage

// File: rtl/sbox.sv
// NUM parallel SM4 byte substitutions; byte i of din maps to byte i of dout.
module sbox #(
  parameter int unsigned NUM = 4
) (
  input  logic [8*NUM-1:0] din,
  output logic [8*NUM-1:0] dout
);

  // Entry 0 is the most significant byte of the first row.
  localparam logic [0:255][7:0] TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // Independent table lookup per byte lane.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      dout[8*i +: 8] = TABLE[din[8*i +: 8]];
    end
  end

endmodule

// File: rtl/sm4_cipher_core.sv
// Iterative SM4 encrypt/decrypt core: one round per clock, 32 rounds per block,
// valid/ready on both sides, result registered and held until consumed.
module sm4_cipher_core
  import sm4_pkg::*;
#(
  parameter int unsigned ROUNDS = SM4_ROUNDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1023:0] round_keys,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  input  logic          in_decrypt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

  sm4_core_state_e state_q, state_d;
  logic [4:0]      rnd_q, rnd_d;
  logic [127:0]    x_q, x_d;
  logic            decrypt_q, decrypt_d;
  logic [127:0]    out_data_q, out_data_d;

  sm4_word_t  x0, x1, x2, x3;
  sm4_word_t  rk, t_in, t_out, x_new;
  logic [4:0] rk_idx;
  logic       accept;

  assign x0 = x_q[127:96];
  assign x1 = x_q[95:64];
  assign x2 = x_q[63:32];
  assign x3 = x_q[31:0];

  // Decryption walks the same key schedule backwards.
  assign rk_idx = decrypt_q ? (LAST_RND - rnd_q) : rnd_q;
  assign rk     = round_keys[{rk_idx, 5'd0} +: 32];
  assign t_in   = x1 ^ x2 ^ x3 ^ rk;

  sbox #(
    .NUM(4)
  ) u_sbox (
    .din (t_in),
    .dout(t_out)
  );

  assign x_new = x0 ^ sm4_l(t_out);

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;

  // Next-state: load on acceptance, one round per RUN cycle, hold result in DONE.
  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    x_d        = x_q;
    decrypt_d  = decrypt_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d   = RUN;
          x_d       = in_data;
          decrypt_d = in_decrypt;
          rnd_d     = '0;
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        x_d = {x1, x2, x3, x_new};
        if (rnd_q == LAST_RND) begin
          state_d    = DONE;
          // Reverse transform R applied while capturing the result.
          out_data_d = {x_new, x3, x2, x1};
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rnd_q      <= '0;
      x_q        <= '0;
      decrypt_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      x_q        <= x_d;
      decrypt_q  <= decrypt_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_sm4_cipher_core.sv
// Self-checking bench for sm4_cipher_core with an algorithmic SM4 model.
module tb_sm4_cipher_core;

  localparam int NUM_RANDOM = 400;
  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] FK  = 128'ha3b1bac656aa3350677d9197b27022dc;

  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1023:0] round_keys = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  in_data = '0;
  logic          in_decrypt = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [127:0]  out_data;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  sm4_cipher_core #(
    .ROUNDS(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .round_keys(round_keys),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_decrypt(in_decrypt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rol(input logic [31:0] a, input int n);
    return (a << n) | (a >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[a[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [1023:0] key_exp(input logic [127:0] mk);
    logic [31:0]   k [36];
    logic [31:0]   ck, b;
    logic [1023:0] rks;
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ FK[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4 * i + j) * 7);
      b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ rol(b, 13) ^ rol(b, 23);
      rks[32*i +: 32] = k[i+4];
    end
    return rks;
  endfunction

  function automatic logic [127:0] crypt(input logic [1023:0] rks, input logic [127:0] blk,
                                         input logic dec);
    logic [31:0] x [36];
    logic [31:0] rk, b;
    for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      rk = dec ? rks[32*(31-i) +: 32] : rks[32*i +: 32];
      b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk);
      x[i+4] = x[i] ^ b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- cycle compare process ----------------
  logic         m_pending = 1'b0;
  int           m_ready_cyc = 0;
  logic [127:0] m_data = '0;
  logic         exp_ov, exp_ir;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pending = 1'b0;
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_out_data", out_data, 128'd0);
    end else begin
      exp_ov = m_pending && (cyc >= m_ready_cyc);
      exp_ir = !m_pending || (exp_ov && out_ready);
      chk("cmp_out_valid", {127'd0, out_valid}, {127'd0, exp_ov});
      chk("cmp_in_ready", {127'd0, in_ready}, {127'd0, exp_ir});
      chk("cmp_busy", {127'd0, busy}, {127'd0, m_pending});
      if (exp_ov) chk("cmp_out_data", out_data, m_data);
      if (exp_ov && out_ready) m_pending = 1'b0;
      if (exp_ir && in_valid) begin
        m_pending   = 1'b1;
        m_ready_cyc = cyc + 33;
        m_data      = crypt(round_keys, in_data, in_decrypt);
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic send(input logic [127:0] blk, input logic dec, output int acc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = blk;
    in_decrypt = dec;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", {127'd0, in_ready}, 128'd1);
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_decrypt = 1'($urandom);
  endtask

  task automatic wait_out(output logic [127:0] data, output int at);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("out_timeout", {127'd0, out_valid}, 128'd1);
    data = out_data;
    at = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] ks;
    logic [127:0]  d, key, blk, c;
    int            acc, at, acc2;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Pin the model against the published vector and key schedule.
    ks = key_exp(KEY);
    chk("model_rk0", {96'd0, ks[31:0]}, {96'd0, 32'hf12186f9});
    chk("model_rk31", {96'd0, ks[1023:992]}, {96'd0, 32'h9124a012});
    chk("model_enc", crypt(ks, PT, 1'b0), CT);
    chk("model_dec", crypt(ks, CT, 1'b1), PT);
    round_keys = ks;

    // Encrypt vector and latency.
    send(PT, 1'b0, acc);
    wait_out(d, at);
    chk("enc_data", d, CT);
    chk("enc_latency", 128'(at - acc), 128'd33);
    @(posedge clk); #1;

    // Decrypt vector.
    send(CT, 1'b1, acc);
    wait_out(d, at);
    chk("dec_data", d, PT);
    chk("dec_latency", 128'(at - acc), 128'd33);
    @(posedge clk); #1;

    // Backpressure in DONE.
    out_ready = 1'b0;
    send(PT, 1'b0, acc);
    wait_out(d, at);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_data", out_data, CT);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      chk("bp_busy", {127'd0, busy}, 128'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {127'd0, out_valid}, 128'd0);
    chk("bp_release_ready", {127'd0, in_ready}, 128'd1);
    chk("bp_release_busy", {127'd0, busy}, 128'd0);

    // Back-to-back: consume and accept on the same edge.
    send(PT, 1'b0, acc);
    wait_out(d, at);
    chk("b2b_first", d, CT);
    in_valid = 1'b1;
    in_data = CT;
    in_decrypt = 1'b1;
    chk("b2b_in_ready", {127'd0, in_ready}, 128'd1);
    acc2 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid_drop", {127'd0, out_valid}, 128'd0);
    chk("b2b_busy", {127'd0, busy}, 128'd1);
    wait_out(d, at);
    chk("b2b_second", d, PT);
    chk("b2b_latency", 128'(at - acc2), 128'd33);
    @(posedge clk); #1;

    // Reset mid-RUN acts immediately.
    send(PT, 1'b0, acc);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("arst_busy", {127'd0, busy}, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(PT, 1'b0, acc);
    wait_out(d, at);
    chk("post_rst_data", d, CT);
    chk("post_rst_latency", 128'(at - acc), 128'd33);
    @(posedge clk); #1;

    // Input noise during RUN must not disturb the result.
    send(PT, 1'b0, acc);
    repeat (25) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_decrypt = 1'($urandom);
    end
    in_valid = 1'b0;
    wait_out(d, at);
    chk("noise_data", d, CT);
    chk("noise_latency", 128'(at - acc), 128'd33);
    @(posedge clk); #1;

    // Random key/block round trips.
    for (int i = 0; i < NUM_RANDOM; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      blk = {$urandom, $urandom, $urandom, $urandom};
      round_keys = key_exp(key);
      send(blk, 1'b0, acc);
      wait_out(c, at);
      @(posedge clk); #1;
      send(c, 1'b0 ^ 1'b1, acc);
      wait_out(d, at);
      chk($sformatf("roundtrip_%0d", i), d, blk);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
